// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed seven-segment driver.
//   CODE_W       width of one symbol code
//   SYM_*        symbol codes for the letter/punctuation glyphs
//   SEG_*        active-low segment patterns, bit order {a,b,c,d,e,f,g}
package seg7_pkg;

  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] SYM_C     = 5'd10;
  localparam logic [CODE_W-1:0] SYM_L     = 5'd11;
  localparam logic [CODE_W-1:0] SYM_S     = 5'd12;
  localparam logic [CODE_W-1:0] SYM_D     = 5'd13;
  localparam logic [CODE_W-1:0] SYM_O     = 5'd14;
  localparam logic [CODE_W-1:0] SYM_P     = 5'd15;
  localparam logic [CODE_W-1:0] SYM_E     = 5'd16;
  localparam logic [CODE_W-1:0] SYM_N     = 5'd17;
  localparam logic [CODE_W-1:0] SYM_DASH  = 5'd18;
  localparam logic [CODE_W-1:0] SYM_BLANK = 5'd19;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_P     = 7'b0011000;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_N     = 7'b1101010;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational symbol-code to segment-pattern decoder.
//   code  in  CODE_W  symbol code
//   seg   out 7       active-low segments {a,b,c,d,e,f,g}
// Unassigned codes (20..31) decode to blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [6:0]        seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'd0:      seg = SEG_0;
      5'd1:      seg = SEG_1;
      5'd2:      seg = SEG_2;
      5'd3:      seg = SEG_3;
      5'd4:      seg = SEG_4;
      5'd5:      seg = SEG_5;
      5'd6:      seg = SEG_6;
      5'd7:      seg = SEG_7;
      5'd8:      seg = SEG_8;
      5'd9:      seg = SEG_9;
      SYM_C:     seg = SEG_C;
      SYM_L:     seg = SEG_L;
      SYM_S:     seg = SEG_5;
      SYM_D:     seg = SEG_D;
      SYM_O:     seg = SEG_0;
      SYM_P:     seg = SEG_P;
      SYM_E:     seg = SEG_E;
      SYM_N:     seg = SEG_N;
      SYM_DASH:  seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: N-digit common-anode multiplexed seven-segment driver
// with a double-buffered frame of symbol codes.
//   clk, rst_n   clock, synchronous active-low reset
//   codes_in     NUM_DIGITS x 5-bit codes, digit 0 in the low bits (rightmost)
//   load         pulse: take codes_in as the next frame
//   blink_mask   per-digit blink enable (only with SEG7_BLINK_EN)
//   pending      a loaded frame waits for the next frame boundary
//   frame_tick   high for the cycle in which the scan wraps to digit 0
//   an           active-low digit enables, one-hot-cold
//   seg          active-low segments {a,b,c,d,e,f,g}
// Build option: define SEG7_BLINK_EN to enable per-digit blinking with a
// phase that toggles every BLINK_DIV frames.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CODE_W*NUM_DIGITS-1:0] codes_in,
  input  logic                         load,
  input  logic [NUM_DIGITS-1:0]        blink_mask,
  output logic                         pending,
  output logic                         frame_tick,
  output logic [NUM_DIGITS-1:0]        an,
  output logic [6:0]                   seg
);

  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int FRAME_W = CODE_W * NUM_DIGITS;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRAME_W-1:0]    active_q, active_d;
  logic [FRAME_W-1:0]    pbuf_q, pbuf_d;
  logic                  pending_q, pending_d;
  logic                  run_q, run_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic [CODE_W-1:0]     cur_code;
  logic [6:0]            dec_seg;
  logic                  term, wrap, blank_now;

  // Mux the code of the currently indexed digit out of the active frame.
  always_comb begin
    cur_code = SYM_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_code = active_q[i*CODE_W +: CODE_W];
    end
  end

  seg7_decode u_decode (
    .code (cur_code),
    .seg  (dec_seg)
  );

`ifdef SEG7_BLINK_EN
  localparam int FC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            phase_q, phase_d;
  logic            cur_blink;

  always_comb begin
    cur_blink = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_blink = blink_mask[i];
    end
  end

  // Count completed frames; flip the blink phase every BLINK_DIV of them.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (wrap) begin
      if (frame_cnt_q == FC_W'(BLINK_DIV - 1)) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blank_now = phase_q & cur_blink;
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blank_now         = 1'b0;
`endif

  always_comb begin
    term = (presc_q == PRESC_W'(SCAN_DIV - 1));
    wrap = term && (idx_q == IDX_W'(NUM_DIGITS - 1));

    presc_d = term ? '0 : presc_q + PRESC_W'(1);
    idx_d   = idx_q;
    if (term) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

    // Registered so that it is high exactly while the wrap is about to happen.
    frame_tick_d = (presc_d == PRESC_W'(SCAN_DIV - 1)) &&
                   (idx_d == IDX_W'(NUM_DIGITS - 1));

    // A load on the wrap cycle bypasses the pending buffer entirely.
    active_d  = active_q;
    pbuf_d    = pbuf_q;
    pending_d = pending_q;
    if (load && wrap) begin
      active_d  = codes_in;
      pending_d = 1'b0;
    end else if (load) begin
      pbuf_d    = codes_in;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      active_d  = pbuf_q;
      pending_d = 1'b0;
    end

    // run_q holds the display dark for the first cycle after reset release.
    run_d = 1'b1;
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (run_q) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = blank_now ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      active_q     <= {NUM_DIGITS{SYM_BLANK}};
      pbuf_q       <= {NUM_DIGITS{SYM_BLANK}};
      pending_q    <= 1'b0;
      run_q        <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pbuf_q       <= pbuf_d;
      pending_q    <= pending_d;
      run_q        <= run_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int B  = 2;
  localparam int SN = S * N;
`ifdef SEG7_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [19:0] codes_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        pending, frame_tick;
  logic [3:0]  an;
  logic [6:0]  seg;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .codes_in   (codes_in),
    .load       (load),
    .blink_mask (blink_mask),
    .pending    (pending),
    .frame_tick (frame_tick),
    .an         (an),
    .seg        (seg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: k = clock edges since reset release.
  int         k;
  logic [4:0] m_act [N];
  logic [4:0] m_pnd [N];
  bit         m_pending;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  bit         e_tick;

  function automatic logic [6:0] pat(input logic [4:0] c);
    case (c)
      5'd0:  return 7'b0000001;  5'd1:  return 7'b1001111;
      5'd2:  return 7'b0010010;  5'd3:  return 7'b0000110;
      5'd4:  return 7'b1001100;  5'd5:  return 7'b0100100;
      5'd6:  return 7'b0100000;  5'd7:  return 7'b0001111;
      5'd8:  return 7'b0000000;  5'd9:  return 7'b0000100;
      5'd10: return 7'b0110001;  5'd11: return 7'b1110001;
      5'd12: return 7'b0100100;  5'd13: return 7'b1000010;
      5'd14: return 7'b0000001;  5'd15: return 7'b0011000;
      5'd16: return 7'b0110000;  5'd17: return 7'b1101010;
      5'd18: return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then
  // settle to the sampling point 1 time unit after the edge.
  task automatic clk_step(input bit ld, input logic [19:0] cw);
    int  d;
    bit  wrap;
    load     = ld;
    codes_in = cw;
    @(posedge clk);
    if (!rst_n) begin
      k = 0;
      for (int i = 0; i < N; i++) begin m_act[i] = 5'd19; m_pnd[i] = 5'd19; end
      m_pending = 1'b0;
      e_an  = 4'b1111;
      e_seg = 7'b1111111;
      e_tick = 1'b0;
    end else begin
      d = (k / S) % N;
      if (k == 0) begin
        e_an  = 4'b1111;
        e_seg = 7'b1111111;
      end else begin
        e_an  = ~(4'b0001 << d);
        e_seg = pat(m_act[d]);
        if (BLINK && (((k / SN) / B) % 2 == 1) && blink_mask[d]) e_seg = 7'b1111111;
      end
      wrap = ((k + 1) % SN == 0);
      if (ld && wrap) begin
        for (int i = 0; i < N; i++) m_act[i] = cw[5*i +: 5];
        m_pending = 1'b0;
      end else if (ld) begin
        for (int i = 0; i < N; i++) m_pnd[i] = cw[5*i +: 5];
        m_pending = 1'b1;
      end else if (wrap && m_pending) begin
        for (int i = 0; i < N; i++) m_act[i] = m_pnd[i];
        m_pending = 1'b0;
      end
      k++;
      e_tick = ((k + 1) % SN == 0);
    end
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      clk_step(1'b0, '0);
      n_checks += 3;
      if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got %b want 1111", an); end
      if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg got %b want 1111111", seg); end
      if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", pending); end
    end
    rst_n = 1'b1;
    clk_step(1'b0, '0);
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL release1_an got %b want 1111", an); end
    clk_step(1'b0, '0);
    n_checks += 2;
    if (an !== 4'b1110) begin n_fail++; $display("FAIL release2_an got %b want 1110", an); end
    if (seg !== 7'b1111111) begin n_fail++; $display("FAIL release2_seg got %b want 1111111", seg); end
  endtask

  task automatic test_scan();
    clk_step(1'b1, {5'd3, 5'd2, 5'd1, 5'd0});
    for (int c = 0; c < 3 * SN; c++) begin
      clk_step(1'b0, '0);
      n_checks += 4;
      if (an !== e_an) begin n_fail++; $display("FAIL scan_an k=%0d got %b want %b", k, an, e_an); end
      if (seg !== e_seg) begin n_fail++; $display("FAIL scan_seg k=%0d got %b want %b", k, seg, e_seg); end
      if (frame_tick !== e_tick) begin n_fail++; $display("FAIL scan_tick k=%0d got %b want %b", k, frame_tick, e_tick); end
      if (pending !== m_pending) begin n_fail++; $display("FAIL scan_pending k=%0d got %b want %b", k, pending, m_pending); end
      if (c >= 2 * SN) begin
        n_checks++;
        if ((an == 4'b1110 && seg !== 7'b0000001) || (an == 4'b1101 && seg !== 7'b1001111) ||
            (an == 4'b1011 && seg !== 7'b0010010) || (an == 4'b0111 && seg !== 7'b0000110)) begin
          n_fail++; $display("FAIL scan_digit an=%b got %b", an, seg);
        end
      end
    end
  endtask

  task automatic test_deferred();
    while (k % SN != 5) clk_step(1'b0, '0);
    clk_step(1'b1, {5'd16, 5'd17, 5'd11, 5'd10});
    n_checks++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL defer_pending got %b want 1", pending); end
    for (int c = 0; c < 2 * SN; c++) begin
      clk_step(1'b0, '0);
      n_checks += 3;
      if (an !== e_an) begin n_fail++; $display("FAIL defer_an k=%0d got %b want %b", k, an, e_an); end
      if (seg !== e_seg) begin n_fail++; $display("FAIL defer_seg k=%0d got %b want %b", k, seg, e_seg); end
      if (pending !== m_pending) begin n_fail++; $display("FAIL defer_pending k=%0d got %b want %b", k, pending, m_pending); end
    end
    n_checks++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL defer_cleared got %b want 0", pending); end
  endtask

  task automatic test_back_to_back();
    while (k % SN != 3) clk_step(1'b0, '0);
    clk_step(1'b1, {5'd9, 5'd9, 5'd9, 5'd9});
    clk_step(1'b0, '0);
    clk_step(1'b1, {5'd18, 5'd7, 5'd6, 5'd5});
    n_checks++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL b2b_pending got %b want 1", pending); end
    for (int c = 0; c < 2 * SN; c++) begin
      clk_step(1'b0, '0);
      n_checks += 2;
      if (an !== e_an) begin n_fail++; $display("FAIL b2b_an k=%0d got %b want %b", k, an, e_an); end
      if (seg !== e_seg) begin n_fail++; $display("FAIL b2b_seg k=%0d got %b want %b", k, seg, e_seg); end
      if (seg === 7'b0000100) begin n_checks++; n_fail++; $display("FAIL b2b_stale got %b", seg); end
    end
  endtask

  task automatic test_wrap_load();
    int guard = 0;
    while (frame_tick !== 1'b1 && guard < 2 * SN) begin clk_step(1'b0, '0); guard++; end
    n_checks++;
    if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL wrap_wait got %b want 1", frame_tick); end
    clk_step(1'b1, {5'd4, 5'd15, 5'd13, 5'd8});
    n_checks++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL wrap_pending got %b want 0", pending); end
    clk_step(1'b0, '0);
    n_checks += 2;
    if (an !== 4'b1110) begin n_fail++; $display("FAIL wrap_an got %b want 1110", an); end
    if (seg !== 7'b0000000) begin n_fail++; $display("FAIL wrap_seg got %b want 0000000", seg); end
  endtask

  task automatic test_illegal_and_reset();
    clk_step(1'b1, {4{5'd25}});
    for (int c = 0; c < 2 * SN; c++) begin
      clk_step(1'b0, '0);
      if (c >= SN) begin
        n_checks++;
        if (seg !== 7'b1111111) begin n_fail++; $display("FAIL illegal_seg k=%0d got %b want 1111111", k, seg); end
      end
    end
    clk_step(1'b1, {5'd1, 5'd2, 5'd3, 5'd4});
    clk_step(1'b0, '0);
    rst_n = 1'b0;
    clk_step(1'b0, '0);
    n_checks += 4;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL midrst_an got %b want 1111", an); end
    if (seg !== 7'b1111111) begin n_fail++; $display("FAIL midrst_seg got %b want 1111111", seg); end
    if (pending !== 1'b0) begin n_fail++; $display("FAIL midrst_pending got %b want 0", pending); end
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL midrst_tick got %b want 0", frame_tick); end
    rst_n = 1'b1;
    for (int c = 0; c < SN + 2; c++) begin
      clk_step(1'b0, '0);
      n_checks += 2;
      if (an !== e_an) begin n_fail++; $display("FAIL postrst_an k=%0d got %b want %b", k, an, e_an); end
      if (seg !== 7'b1111111) begin n_fail++; $display("FAIL postrst_seg k=%0d got %b want 1111111", k, seg); end
    end
  endtask

  task automatic test_blink();
    blink_mask = 4'b0001;
    clk_step(1'b1, {5'd3, 5'd2, 5'd1, 5'd0});
    for (int c = 0; c < 6 * SN; c++) begin
      clk_step(1'b0, '0);
      n_checks += 2;
      if (an !== e_an) begin n_fail++; $display("FAIL blink_an k=%0d got %b want %b", k, an, e_an); end
      if (seg !== e_seg) begin n_fail++; $display("FAIL blink_seg k=%0d got %b want %b", k, seg, e_seg); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (c % SN == 0) blink_mask = 4'($urandom);
      clk_step(($urandom % 6) == 0, 20'($urandom));
      n_checks += 4;
      if (an !== e_an) begin n_fail++; $display("FAIL rand_an k=%0d got %b want %b", k, an, e_an); end
      if (seg !== e_seg) begin n_fail++; $display("FAIL rand_seg k=%0d got %b want %b", k, seg, e_seg); end
      if (frame_tick !== e_tick) begin n_fail++; $display("FAIL rand_tick k=%0d got %b want %b", k, frame_tick, e_tick); end
      if (pending !== m_pending) begin n_fail++; $display("FAIL rand_pending k=%0d got %b want %b", k, pending, m_pending); end
    end
  endtask

  initial begin
    k = 0;
    m_pending = 1'b0;
    test_reset();
    test_scan();
    test_deferred();
    test_back_to_back();
    test_wrap_load();
    test_illegal_and_reset();
    test_blink();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
